reu_ram_sched: RTL

Time-slot scheduler that shares one fixed-latency expansion-memory port (SDRAM controller side) between two clients: client 0 is the REU RAM side and client 1 is a cartridge/GeoRAM-style requester.
- Each granted client sees a fixed-length `cN_cycle` window, compatible with the REU's count-and-sample RAM handshake.
- The block also inserts periodic refresh slots.
- It sits between the clients and the SDRAM controller, one level below the C64 top.

---
 rtl/reu_ram_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/reu_ram_sched.sv
// rtl/reu_ram_sched.sv - two-client time-slot scheduler for one fixed-latency memory port
// Every grant owns a SLOT_LEN window, followed by a one-clock gap; refresh slots are inserted on demand.
module reu_ram_sched #(
   parameter int SLOT_LEN    = 4,
   parameter int MEM_LAT     = 1,
   parameter int REFRESH_INT = 384
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        c0_req_i,
   input  logic [24:0] c0_addr_i,
   input  logic        c0_we_i,
   input  logic [7:0]  c0_wdata_i,
   output logic        c0_cycle_o,
   input  logic        c1_req_i,
   input  logic [24:0] c1_addr_i,
   input  logic        c1_we_i,
   input  logic [7:0]  c1_wdata_i,
   output logic        c1_cycle_o,
   output logic [7:0]  rdata_o,
   output logic        mem_req_o,
   output logic [24:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [7:0]  mem_wdata_o,
   input  logic [7:0]  mem_rdata_i,
   output logic        mem_refresh_o
);

   localparam int KW = (SLOT_LEN > 2) ? $clog2(SLOT_LEN) : 1;
   localparam int RW = (REFRESH_INT > 2) ? $clog2(REFRESH_INT) : 1;
   localparam logic [1:0] OWN_C0  = 2'd0;
   localparam logic [1:0] OWN_C1  = 2'd1;
   localparam logic [1:0] OWN_REF = 2'd2;

   typedef enum logic [1:0] {IDLE, SLOT, GAP} state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [1:0]    owner_q, owner_d;
   logic          last_q, last_d;
   logic [RW-1:0] ref_cnt_q, ref_cnt_d;
   logic          ref_pend_q, ref_pend_d;
   logic          ref_clr;
   logic          c0_cycle_q, c0_cycle_d, c1_cycle_q, c1_cycle_d;
   logic          mem_req_q, mem_req_d, mem_refresh_q, mem_refresh_d;
   logic [24:0]   mem_addr_q, mem_addr_d;
   logic          mem_we_q, mem_we_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         k_q           <= '0;
         owner_q       <= OWN_C0;
         last_q        <= 1'b1;
         ref_cnt_q     <= '0;
         ref_pend_q    <= 1'b0;
         c0_cycle_q    <= 1'b0;
         c1_cycle_q    <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_refresh_q <= 1'b0;
         mem_addr_q    <= '0;
         mem_we_q      <= 1'b0;
         mem_wdata_q   <= '0;
         rdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         owner_q       <= owner_d;
         last_q        <= last_d;
         ref_cnt_q     <= ref_cnt_d;
         ref_pend_q    <= ref_pend_d;
         c0_cycle_q    <= c0_cycle_d;
         c1_cycle_q    <= c1_cycle_d;
         mem_req_q     <= mem_req_d;
         mem_refresh_q <= mem_refresh_d;
         mem_addr_q    <= mem_addr_d;
         mem_we_q      <= mem_we_d;
         mem_wdata_q   <= mem_wdata_d;
         rdata_q       <= rdata_d;
      end
   end

   // last_q names the client served most recently; on contention the other one wins
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      owner_d = owner_q;
      last_d  = last_q;
      ref_clr = 1'b0;
      case (state_q)
         IDLE: begin
            k_d = '0;
            if (ref_pend_q) begin
               owner_d = OWN_REF;
               ref_clr = 1'b1;
               state_d = SLOT;
            end else if (c0_req_i && c1_req_i) begin
               owner_d = last_q ? OWN_C0 : OWN_C1;
               last_d  = ~last_q;
               state_d = SLOT;
            end else if (c0_req_i) begin
               owner_d = OWN_C0;
               last_d  = 1'b0;
               state_d = SLOT;
            end else if (c1_req_i) begin
               owner_d = OWN_C1;
               last_d  = 1'b1;
               state_d = SLOT;
            end
         end
         SLOT: begin
            if (k_q == KW'(SLOT_LEN - 1)) state_d = GAP;
            else                          k_d = k_q + 1'b1;
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ref_cnt_d  = (ref_cnt_q == RW'(REFRESH_INT - 1)) ? '0 : ref_cnt_q + 1'b1;
      ref_pend_d = (ref_cnt_q == RW'(REFRESH_INT - 1)) | (ref_pend_q & ~ref_clr);
   end

   always_comb begin
      c0_cycle_d    = (state_d == SLOT) && (owner_d == OWN_C0);
      c1_cycle_d    = (state_d == SLOT) && (owner_d == OWN_C1);
      mem_req_d     = (state_q == SLOT) && (k_q == '0) && (owner_q != OWN_REF);
      mem_refresh_d = (state_q == SLOT) && (k_q == '0) && (owner_q == OWN_REF);
      mem_addr_d    = mem_addr_q;
      mem_we_d      = mem_we_q;
      mem_wdata_d   = mem_wdata_q;
      rdata_d       = rdata_q;
      if (mem_req_d) begin
         mem_addr_d  = (owner_q == OWN_C1) ? c1_addr_i  : c0_addr_i;
         mem_we_d    = (owner_q == OWN_C1) ? c1_we_i    : c0_we_i;
         mem_wdata_d = (owner_q == OWN_C1) ? c1_wdata_i : c0_wdata_i;
      end
      if ((state_q == SLOT) && (owner_q != OWN_REF) && !mem_we_q && (k_q == KW'(1 + MEM_LAT)))
         rdata_d = mem_rdata_i;
   end

   assign c0_cycle_o    = c0_cycle_q;
   assign c1_cycle_o    = c1_cycle_q;
   assign rdata_o       = rdata_q;
   assign mem_req_o     = mem_req_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_we_o      = mem_we_q;
   assign mem_wdata_o   = mem_wdata_q;
   assign mem_refresh_o = mem_refresh_q;

endmodule
